// File: rtl/idli_pkg.sv
// Shared types for the idli core and its SQI memory responder.
// SQI link nibble, command, address and responder FSM encodings.
package idli_pkg;

  typedef logic [3:0] sqi_data_t;

  typedef enum logic {
    SQI_MEM_LO,
    SQI_MEM_HI
  } sqi_mem_t;

  typedef enum logic [7:0] {
    SQI_CMD_WRITE = 8'h02,
    SQI_CMD_READ  = 8'h03
  } sqi_cmd_t;

  typedef logic [23:0] sqi_addr_t;

  localparam int SQI_DUMMY_CYCLES = 2;

  typedef enum logic [2:0] {
    CMD,
    ADDR,
    DUMMY,
    RD,
    WR,
    IGNORE
  } sqi_mem_state_t;

endpackage

// File: rtl/idli_sqi_ram.sv
// Byte array behind the SQI responder.
// Synchronous write port and registered read port.
module idli_sqi_ram #(
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [7:0]        rdata
);

  logic [7:0] mem [2**ADDR_W];

  // Write on request; always fetch the byte at the next address.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/idli_sqi_mem.sv
// SQI SRAM responder: quad-mode READ/WRITE with auto-increment.
// Read data comes from the RAM register, selected by nibble phase.
module idli_sqi_mem
  import idli_pkg::*;
#(
  parameter int ADDR_W = 17
) (
  input  logic      i_clk,
  input  logic      i_rst_n,
  input  logic      i_sqi_cs,
  input  sqi_data_t i_sqi_sio,
  output sqi_data_t o_sqi_sio,
  output logic      o_sqi_oe
);

  localparam logic [ADDR_W-1:0] ONE = 1;
  localparam logic [2:0] DUMMY_LAST = 3'(SQI_DUMMY_CYCLES - 1);

  sqi_mem_state_t    state, state_n;
  logic [2:0]        cnt, cnt_n;
  logic [ADDR_W-1:0] addr, addr_n;
  logic              phase, phase_n;
  logic              oe, oe_n;
  logic              op, op_n;
  sqi_data_t         hold, hold_n;
  logic              we;
  logic [7:0]        cmd;
  logic [7:0]        rdata;

  assign cmd = {hold, i_sqi_sio};

  // Next-state decode for the command/address/data sequence.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    addr_n  = addr;
    phase_n = phase;
    oe_n    = oe;
    op_n    = op;
    hold_n  = hold;
    we      = 1'b0;
    if (i_sqi_cs) begin
      state_n = CMD;
      cnt_n   = 3'd0;
      phase_n = 1'b0;
      oe_n    = 1'b0;
    end else begin
      unique case (state)
        CMD: begin
          if (cnt == 3'd0) begin
            hold_n = i_sqi_sio;
            cnt_n  = 3'd1;
          end else begin
            cnt_n = 3'd0;
            if (cmd == SQI_CMD_READ) begin
              state_n = ADDR;
              op_n    = 1'b0;
            end else if (cmd == SQI_CMD_WRITE) begin
              state_n = ADDR;
              op_n    = 1'b1;
            end else begin
              state_n = IGNORE;
            end
          end
        end
        ADDR: begin
          addr_n = {addr[ADDR_W-5:0], i_sqi_sio};
          if (cnt == 3'd5) begin
            cnt_n   = 3'd0;
            phase_n = 1'b0;
            state_n = op ? WR : DUMMY;
          end else begin
            cnt_n = cnt + 3'd1;
          end
        end
        DUMMY: begin
          if (cnt == DUMMY_LAST) begin
            cnt_n   = 3'd0;
            state_n = RD;
            oe_n    = 1'b1;
            phase_n = 1'b0;
          end else begin
            cnt_n = cnt + 3'd1;
          end
        end
        RD: begin
          phase_n = ~phase;
          if (phase) begin
            addr_n = addr + ONE;
          end
        end
        WR: begin
          phase_n = ~phase;
          if (!phase) begin
            hold_n = i_sqi_sio;
          end else begin
            we     = 1'b1;
            addr_n = addr + ONE;
          end
        end
        IGNORE: begin
        end
        default: begin
          state_n = IGNORE;
        end
      endcase
    end
  end

  // State registers; reset wins over chip select.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= CMD;
      cnt   <= 3'd0;
      addr  <= '0;
      phase <= 1'b0;
      oe    <= 1'b0;
      op    <= 1'b0;
      hold  <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      addr  <= addr_n;
      phase <= phase_n;
      oe    <= oe_n;
      op    <= op_n;
      hold  <= hold_n;
    end
  end

  idli_sqi_ram #(
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk   (i_clk),
    .we    (we & i_rst_n),
    .waddr (addr),
    .wdata ({hold, i_sqi_sio}),
    .raddr (addr_n),
    .rdata (rdata)
  );

  assign o_sqi_oe  = oe;
  assign o_sqi_sio = !oe   ? 4'h0 :
                     phase ? rdata[3:0] :
                             rdata[7:4];

endmodule

// File: tb/tb_idli_sqi_mem.sv
// Directed bench for the SQI responder.
// Writes known bytes, then reads them back nibble by nibble.
module tb_idli_sqi_mem;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cs;
  logic [3:0] sio_in;
  logic [3:0] sio_out;
  logic       oe;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [23:0] addr;
    logic [7:0]  exp;
  } rd_vec_t;

  rd_vec_t tbl[11];

  always #5 clk = ~clk;

  idli_sqi_mem #(
    .ADDR_W(17)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_sqi_cs  (cs),
    .i_sqi_sio (sio_in),
    .o_sqi_sio (sio_out),
    .o_sqi_oe  (oe)
  );

  task automatic check(input string name,
                       input logic [7:0] act,
                       input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic c, input logic [3:0] d);
    cs     = c;
    sio_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic tx_start(input logic [7:0] cmd,
                          input logic [23:0] a);
    logic [3:0] n;
    step(1'b0, cmd[7:4]);
    step(1'b0, cmd[3:0]);
    for (int i = 5; i >= 0; i--) begin
      n = a[i*4 +: 4];
      step(1'b0, n);
    end
  endtask

  task automatic tx_end();
    step(1'b1, 4'h0);
  endtask

  task automatic wr_byte(input logic [7:0] b);
    step(1'b0, b[7:4]);
    step(1'b0, b[3:0]);
  endtask

  task automatic dummy();
    step(1'b0, 4'h0);
    step(1'b0, 4'h0);
  endtask

  task automatic rd_byte(input string n, input logic [7:0] b);
    check({n, " oe hi"}, {7'd0, oe}, 8'd1);
    check({n, " hi"}, {4'd0, sio_out}, {4'd0, b[7:4]});
    step(1'b0, 4'h0);
    check({n, " oe lo"}, {7'd0, oe}, 8'd1);
    check({n, " lo"}, {4'd0, sio_out}, {4'd0, b[3:0]});
    step(1'b0, 4'h0);
  endtask

  initial begin
    logic [3:0] ign[8];
    tbl[0]  = '{"single",   24'h000010, 8'hA5};
    tbl[1]  = '{"b100",     24'h000100, 8'h11};
    tbl[2]  = '{"b101",     24'h000101, 8'h22};
    tbl[3]  = '{"b102",     24'h000102, 8'h33};
    tbl[4]  = '{"b103",     24'h000103, 8'h44};
    tbl[5]  = '{"wrap_top", 24'h01FFFF, 8'hDE};
    tbl[6]  = '{"wrap_0",   24'h000000, 8'hAD};
    tbl[7]  = '{"alias_lo", 24'h020003, 8'h5A};
    tbl[8]  = '{"alias_hi", 24'h120003, 8'h5A};
    tbl[9]  = '{"abort_wr", 24'h000200, 8'h77};
    tbl[10] = '{"wr_after", 24'h000201, 8'h99};
    ign = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'hF, 4'hF};

    rst_n  = 1'b0;
    cs     = 1'b1;
    sio_in = 4'h0;
    step(1'b0, 4'h3);
    step(1'b0, 4'h3);
    check("reset oe", {7'd0, oe}, 8'd0);
    check("reset sio", {4'd0, sio_out}, 8'd0);
    rst_n = 1'b1;
    tx_end();

    tx_start(8'h02, 24'h000010);
    wr_byte(8'hA5);
    tx_end();

    tx_start(8'h03, 24'h000010);
    check("latency oe pre", {7'd0, oe}, 8'd0);
    step(1'b0, 4'h0);
    check("latency oe dummy1", {7'd0, oe}, 8'd0);
    step(1'b0, 4'h0);
    check("first oe", {7'd0, oe}, 8'd1);
    check("first hi", {4'd0, sio_out}, 8'h0A);
    step(1'b0, 4'h0);
    check("first lo", {4'd0, sio_out}, 8'h05);
    tx_end();
    check("cs high oe", {7'd0, oe}, 8'd0);
    check("cs high sio", {4'd0, sio_out}, 8'd0);

    tx_start(8'h02, 24'h000100);
    wr_byte(8'h11);
    wr_byte(8'h22);
    wr_byte(8'h33);
    wr_byte(8'h44);
    tx_end();
    tx_start(8'h03, 24'h000100);
    dummy();
    rd_byte("burst0", 8'h11);
    rd_byte("burst1", 8'h22);
    rd_byte("burst2", 8'h33);
    rd_byte("burst3", 8'h44);
    tx_end();

    tx_start(8'h02, 24'h01FFFF);
    wr_byte(8'hDE);
    wr_byte(8'hAD);
    tx_end();
    tx_start(8'h03, 24'h01FFFF);
    dummy();
    rd_byte("wrap rd0", 8'hDE);
    rd_byte("wrap rd1", 8'hAD);
    tx_end();

    tx_start(8'h02, 24'h120003);
    wr_byte(8'h5A);
    tx_end();

    step(1'b0, 4'h0);
    step(1'b0, 4'h5);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, ign[i]);
      check("ignore oe", {7'd0, oe}, 8'd0);
    end
    tx_end();

    step(1'b0, 4'h0);
    step(1'b0, 4'h3);
    step(1'b0, 4'h0);
    step(1'b0, 4'h0);
    step(1'b0, 4'h0);
    tx_end();
    tx_start(8'h03, 24'h000100);
    dummy();
    rd_byte("abort addr", 8'h11);
    tx_end();

    tx_start(8'h02, 24'h000200);
    wr_byte(8'h77);
    tx_end();
    tx_start(8'h02, 24'h000200);
    step(1'b0, 4'hF);
    tx_end();
    tx_start(8'h02, 24'h000201);
    wr_byte(8'h99);
    tx_end();

    tx_start(8'h03, 24'h000100);
    dummy();
    check("rst mid hi", {4'd0, sio_out}, 8'h01);
    rst_n = 1'b0;
    step(1'b0, 4'h0);
    check("rst mid oe", {7'd0, oe}, 8'd0);
    check("rst mid sio", {4'd0, sio_out}, 8'd0);
    rst_n = 1'b1;
    tx_end();

    for (int i = 0; i < 11; i++) begin
      tx_start(8'h03, tbl[i].addr);
      dummy();
      rd_byte(tbl[i].name, tbl[i].exp);
      tx_end();
      check({tbl[i].name, " oe off"}, {7'd0, oe}, 8'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
